// File: rtl/wb_ram_burst_if.sv
// Wishbone B4 bus bundle for wb_ram_burst.
// Signal names follow the Wishbone slave port naming.
interface wb_ram_burst_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic [DW-1:0]   wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    output wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    input  wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_err_o, wb_dat_o
  );
endinterface

// File: rtl/wb_ram_burst.sv
// Wishbone B4 on-chip RAM slave with registered-feedback
// bursts, wait states and out-of-range bus errors.
module wb_ram_burst #(
  parameter int    DW          = 32,
  parameter int    AW          = 32,
  parameter int    DEPTH       = 65536,
  parameter int    WAIT_STATES = 0,
  parameter string MEMFILE     = ""
) (
  input logic           wb_clk_i,
  input logic           wb_rst_ni,
  wb_ram_burst_if.slave wb
);
  localparam int BW = DW / 8;
  localparam int OB = $clog2(BW);
  localparam int IW = AW - OB;
  localparam int NW = DEPTH / BW;
  localparam int NB = $clog2(NW);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [IW-1:0] adr_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt;
  logic [IW-1:0] mask;
  logic          ack_q;
  logic          err_q;
  logic [DW-1:0] dat_q;
  logic [DW-1:0] mem [NW];

  logic          req;
  logic          cti_inc;
  logic          beat;
  logic          mem_we;
  logic [NB-1:0] idx_m;
  logic [NB-1:0] nxt_m;
  logic [NB-1:0] adr_m;
  logic          unused_adr;

  assign req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign cti_inc    = wb.wb_cti_i == 3'b010;
  assign idx        = wb.wb_adr_i[AW-1:OB];
  assign beat       = ack_q & req;
  assign mem_we     = beat & wb.wb_we_i;
  assign idx_m      = idx[NB-1:0];
  assign nxt_m      = nxt[NB-1:0];
  assign adr_m      = adr_q[NB-1:0];
  assign unused_adr = ^wb.wb_adr_i[OB-1:0];

  // wrap bursts only advance the low bits; linear uses the full index
  always_comb begin
    unique case (wb.wb_bte_i)
      2'b01:   mask = IW'(3);
      2'b10:   mask = IW'(7);
      2'b11:   mask = IW'(15);
      default: mask = '1;
    endcase
  end

  assign nxt = (adr_q & ~mask) | ((adr_q + 1'b1) & mask);

  function automatic logic oor(input logic [IW-1:0] a);
    return 64'(a) >= 64'(NW);
  endfunction

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      adr_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else if (!wb.wb_cyc_i) begin
      state <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          // an err cycle ends here; its stb is not a new request
          if (req && !err_q) begin
            adr_q <= idx;
            if (WAIT_STATES == 0) begin
              if (oor(idx)) begin
                err_q <= 1'b1;
                dat_q <= '0;
              end else begin
                ack_q <= 1'b1;
                dat_q <= mem[idx_m];
                state <= cti_inc ? BURST : DONE;
              end
            end else begin
              cnt   <= 4'(WAIT_STATES);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (req) begin
            cnt <= cnt - 1'b1;
            if (cnt == 4'd1) begin
              if (oor(adr_q)) begin
                err_q <= 1'b1;
                dat_q <= '0;
                state <= IDLE;
              end else begin
                ack_q <= 1'b1;
                dat_q <= mem[adr_m];
                state <= cti_inc ? BURST : DONE;
              end
            end
          end
        end
        BURST: begin
          if (beat) begin
            if (!cti_inc) begin
              ack_q <= 1'b0;
              state <= IDLE;
            end else if (oor(nxt)) begin
              ack_q <= 1'b0;
              err_q <= 1'b1;
              dat_q <= '0;
              state <= IDLE;
            end else begin
              adr_q <= nxt;
              dat_q <= mem[nxt_m];
            end
          end
        end
        default: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (wb.wb_sel_i[i]) begin
          mem[adr_m][8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
        end
      end
    end
  end

  assign wb.wb_ack_o = ack_q & req;
  assign wb.wb_err_o = err_q & req;
  assign wb.wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb_ram_burst.sv
// Directed bench for wb_ram_burst: DW=32/WS=0 and
// DW=64/WS=3 instances behind one shared master.
module tb_wb_ram_burst;
  logic        clk;
  logic        rst_n;
  logic        dsel;
  logic [31:0] adr;
  logic [63:0] dw;
  logic [7:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic        ack;
  logic        err;
  logic [63:0] rdat;

  int n_chk = 0;
  int n_fail = 0;

  int nack;
  int nerr;
  int flat;
  int llat;
  int gack;
  logic [63:0] rbuf [16];

  wb_ram_burst_if #(.DW(32), .AW(32)) b0 ();
  wb_ram_burst_if #(.DW(64), .AW(32)) b1 ();

  assign b0.wb_adr_i = adr;
  assign b0.wb_dat_i = dw[31:0];
  assign b0.wb_sel_i = sel[3:0];
  assign b0.wb_we_i  = we;
  assign b0.wb_cyc_i = cyc & ~dsel;
  assign b0.wb_stb_i = stb & ~dsel;
  assign b0.wb_cti_i = cti;
  assign b0.wb_bte_i = bte;

  assign b1.wb_adr_i = adr;
  assign b1.wb_dat_i = dw;
  assign b1.wb_sel_i = sel;
  assign b1.wb_we_i  = we;
  assign b1.wb_cyc_i = cyc & dsel;
  assign b1.wb_stb_i = stb & dsel;
  assign b1.wb_cti_i = cti;
  assign b1.wb_bte_i = bte;

  assign ack  = dsel ? b1.wb_ack_o : b0.wb_ack_o;
  assign err  = dsel ? b1.wb_err_o : b0.wb_err_o;
  assign rdat = dsel ? b1.wb_dat_o : {32'h0, b0.wb_dat_o};

  wb_ram_burst #(
    .DW(32), .AW(32), .DEPTH(65536), .WAIT_STATES(0), .MEMFILE("")
  ) u0 (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (b0.slave)
  );

  wb_ram_burst #(
    .DW(64), .AW(32), .DEPTH(65536), .WAIT_STATES(3), .MEMFILE("")
  ) u1 (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (b1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // classic single transfer; lat counts clock edges until ack/err
  task automatic xfer(input bit d, input bit w, input logic [31:0] a,
                      input logic [63:0] data, input logic [7:0] s,
                      input bit hold, output logic [63:0] rd,
                      output int lat, output logic e, output logic na);
    bit done;
    dsel = d; adr = a; dw = data; sel = s; we = w;
    cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    lat = 0; done = 1'b0; rd = '0; e = 1'b0; na = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack || err) begin
        done = 1'b1;
        rd = rdat;
        e = err;
      end
    end
    if (!done) lat = -1;
    @(posedge clk); #1;
    if (hold) begin
      @(negedge clk);
      na = ack;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input bit d, input logic [31:0] a,
                    input logic [63:0] v, input logic [7:0] s,
                    input string tag);
    logic [63:0] r;
    int l;
    logic e, na;
    xfer(d, 1'b1, a, v, s, 1'b0, r, l, e, na);
    chk(tag, 64'(l) + (e ? 64'h100 : 64'h0), d ? 64'd4 : 64'd1);
  endtask

  task automatic rd(input bit d, input logic [31:0] a,
                    input logic [63:0] exp, input string tag);
    logic [63:0] r;
    int l;
    logic e, na;
    xfer(d, 1'b0, a, 64'h0, 8'hFF, 1'b0, r, l, e, na);
    chk({tag, "_lat"}, 64'(l) + (e ? 64'h100 : 64'h0), d ? 64'd4 : 64'd1);
    chk({tag, "_dat"}, r, exp);
  endtask

  // n-beat burst; optional stb gap before beat gap_at, cyc abort at abort_at
  task automatic burst(input bit d, input bit w, input logic [31:0] a,
                       input logic [1:0] bt, input int n, input int gap_at,
                       input int gap_len, input int abort_at,
                       input logic [63:0] wbase);
    int g;
    int pe;
    bit stop;
    nack = 0; nerr = 0; flat = -1; llat = -1; gack = 0;
    g = 0; pe = 0; stop = 1'b0;
    dsel = d; adr = a; we = w; sel = 8'hFF; bte = bt; dw = wbase;
    cti = (n == 1) ? 3'b111 : 3'b010;
    cyc = 1'b1; stb = 1'b1;
    while (!stop) begin
      @(negedge clk);
      if (ack) begin
        if (!stb) gack++;
        if (nack < 16) rbuf[nack[3:0]] = rdat;
        if (nack == 0) flat = pe;
        llat = pe;
        nack++;
      end
      if (err) nerr++;
      if (err || nack >= n || pe >= 100) stop = 1'b1;
      @(posedge clk); #1;
      pe++;
      if (stop || nack == abort_at) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        stop = 1'b1;
      end else begin
        if (nack == gap_at && g < gap_len) begin
          stb = 1'b0;
          g++;
        end else begin
          stb = 1'b1;
        end
        dw = wbase + 64'(nack);
        cti = (nack == n - 1) ? 3'b111 : 3'b010;
      end
    end
  endtask

  initial begin
    logic [63:0] r;
    int l;
    logic e, na, seen;

    rst_n = 1'b0; dsel = 1'b0; adr = '0; dw = '0; sel = '0;
    we = 1'b0; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", b0.wb_ack_o, 0);
    chk("rst_err", b0.wb_err_o, 0);
    chk("rst_dat0", b0.wb_dat_o, 0);
    chk("rst_dat1", b1.wb_dat_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    wr(0, 32'h100, 64'hDEADBEEF, 8'h0F, "wr_full");
    wr(0, 32'h100, 64'h000000AA, 8'h01, "wr_lane0");
    rd(0, 32'h100, 64'hDEADBEAA, "rd_merge");

    wr(1, 32'h0, 64'h12345678, 8'hFF, "ws3_wr");
    xfer(1, 1'b0, 32'h0, 64'h0, 8'hFF, 1'b1, r, l, e, na);
    chk("ws3_lat", 64'(l), 4);
    chk("ws3_dat", r, 64'h12345678);
    chk("ws3_single", na, 0);

    for (int k = 0; k < 4; k++)
      wr(1, 32'(8 * k), 64'h0123_4567_89AB_CD00 + 64'(k), 8'hFF, "wrap_fill");
    burst(1, 1'b0, 32'h18, 2'b01, 4, -1, 0, -1, 64'h0);
    chk("wrap_nack", 64'(nack), 4);
    chk("wrap_first", 64'(flat), 4);
    chk("wrap_span", 64'(llat - flat), 3);
    for (int k = 0; k < 4; k++)
      chk("wrap_beat", rbuf[k], 64'h0123_4567_89AB_CD00 + 64'((k + 3) % 4));

    wr(0, 32'h60, 64'h5A5A5A5A, 8'h0F, "pre60");
    burst(0, 1'b1, 32'h40, 2'b00, 8, 3, 2, -1, 64'hB000_0000);
    chk("lin_nack", 64'(nack), 8);
    chk("lin_nerr", 64'(nerr), 0);
    chk("lin_gap_ack", 64'(gack), 0);
    chk("lin_first", 64'(flat), 1);
    chk("lin_span", 64'(llat - flat), 9);
    for (int k = 0; k < 8; k++)
      rd(0, 32'h40 + 32'(4 * k), 64'hB000_0000 + 64'(k), "lin_word");
    rd(0, 32'h60, 64'h5A5A5A5A, "lin_after");

    wr(0, 32'h0, 64'h11223344, 8'h0F, "pre0");
    xfer(0, 1'b1, 32'h10000, 64'hFFFFFFFF, 8'h0F, 1'b0, r, l, e, na);
    chk("oor_err", e, 1);
    chk("oor_lat", 64'(l), 1);
    chk("oor_dat", r, 0);
    rd(0, 32'h0, 64'h11223344, "oor_mem0");
    burst(0, 1'b0, 32'hFFFC, 2'b00, 4, -1, 0, -1, 64'h0);
    chk("oor_b_ack", 64'(nack), 1);
    chk("oor_b_err", 64'(nerr), 1);
    rd(0, 32'h0, 64'h11223344, "oor_idle");

    wr(0, 32'h208, 64'h77777777, 8'h0F, "pre208");
    burst(0, 1'b1, 32'h200, 2'b00, 8, -1, 0, 2, 64'hC000_0000);
    chk("abort_nack", 64'(nack), 2);
    @(posedge clk); #1;
    rd(0, 32'h200, 64'hC000_0000, "abort_w0");
    rd(0, 32'h204, 64'hC000_0001, "abort_w1");
    rd(0, 32'h208, 64'h7777_7777, "abort_w2");

    wr(0, 32'h300, 64'h12121212, 8'h0F, "pre300");
    dsel = 1'b0; adr = 32'h300; we = 1'b1; dw = 64'hEEEEEEEE;
    sel = 8'h0F; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = ack;
    end
    chk("rst_mid_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_dat0", rdat, 0);
    chk("rst_mid_dat1", b1.wb_dat_o, 0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    rst_n = 1'b1;
    rd(0, 32'h300, 64'h12121212, "rst_nowrite");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
